// File: rtl/procyon_victim_wb_queue_if.sv
// Victim enqueue, lookup and write-back bus signals of the victim queue.
// slave = queue side, master = LSU / bus side.
interface procyon_victim_wb_queue_if #(
  parameter int OPTN_ADDR_WIDTH = 32,
  parameter int DC_LINE_WIDTH   = 256
);
  logic                       i_victim_en;
  logic [OPTN_ADDR_WIDTH-1:0] i_victim_addr;
  logic [DC_LINE_WIDTH-1:0]   i_victim_data;
  logic                       o_full;
  logic                       o_empty;
  logic                       o_overflow;
  logic [OPTN_ADDR_WIDTH-1:0] i_lookup_addr;
  logic                       o_lookup_hit;
  logic                       o_wb_req;
  logic [OPTN_ADDR_WIDTH-1:0] o_wb_addr;
  logic [DC_LINE_WIDTH-1:0]   o_wb_data;
  logic                       i_wb_ack;

  modport slave (
    input  i_victim_en, i_victim_addr, i_victim_data,
    input  i_lookup_addr, i_wb_ack,
    output o_full, o_empty, o_overflow, o_lookup_hit,
    output o_wb_req, o_wb_addr, o_wb_data
  );

  modport master (
    output i_victim_en, i_victim_addr, i_victim_data,
    output i_lookup_addr, i_wb_ack,
    input  o_full, o_empty, o_overflow, o_lookup_hit,
    input  o_wb_req, o_wb_addr, o_wb_data
  );
endinterface

// File: rtl/procyon_victim_wb_queue.sv
// Write-back FIFO for dirty dcache victims: drains entries in order
// over req/ack and answers line-address lookups for the miss path.
module procyon_victim_wb_queue #(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_DC_LINE_SIZE = 32,
  parameter int OPTN_VQ_DEPTH     = 4,
  parameter int DC_LINE_WIDTH     = OPTN_DC_LINE_SIZE * 8,
  parameter int VQ_IDX_WIDTH      = $clog2(OPTN_VQ_DEPTH)
) (
  input logic clk,
  input logic rst,
  procyon_victim_wb_queue_if.slave vq
);

  localparam int AW  = OPTN_ADDR_WIDTH;
  localparam int DW  = DC_LINE_WIDTH;
  localparam int IW  = VQ_IDX_WIDTH;
  localparam int CW  = VQ_IDX_WIDTH + 1;
  localparam int OFW = $clog2(OPTN_DC_LINE_SIZE);
  localparam logic [CW-1:0] FULL_CNT = CW'(OPTN_VQ_DEPTH);
  localparam logic [AW-1:0] LINE_MASK = ~AW'((64'd1 << OFW) - 64'd1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic [OPTN_VQ_DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0] addr_q [OPTN_VQ_DEPTH];
  logic [DW-1:0] data_q [OPTN_VQ_DEPTH];
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          req_q, req_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          overflow_q, overflow_d;

  logic full, empty, enq, deq, hit;
  logic [AW-1:0] victim_line, lookup_line;

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign enq         = vq.i_victim_en && !full;
  assign victim_line = vq.i_victim_addr & LINE_MASK;
  assign lookup_line = vq.i_lookup_addr & LINE_MASK;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    req_d     = 1'b0;
    deq       = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          wb_addr_d = addr_q[head_q];
          wb_data_d = data_q[head_q];
          state_d   = BUSY;
        end
      end
      BUSY: begin
        req_d = 1'b1;
        // ack only counts once the request is actually on the bus
        if (req_q && vq.i_wb_ack) begin
          deq     = 1'b1;
          req_d   = 1'b0;
          head_d  = head_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (enq) valid_d[tail_q] = 1'b1;
    if (deq) valid_d[head_q] = 1'b0;
    tail_d     = enq ? tail_q + 1'b1 : tail_q;
    count_d    = count_q + CW'(enq) - CW'(deq);
    overflow_d = overflow_q | (vq.i_victim_en && full);
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < OPTN_VQ_DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == lookup_line)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      req_q      <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      req_q      <= req_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      overflow_q <= overflow_d;
    end
  end

  // payload storage is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= victim_line;
      data_q[tail_q] <= vq.i_victim_data;
    end
  end

  assign vq.o_full       = full;
  assign vq.o_empty      = empty;
  assign vq.o_overflow   = overflow_q;
  assign vq.o_lookup_hit = hit;
  assign vq.o_wb_req     = req_q;
  assign vq.o_wb_addr    = wb_addr_q;
  assign vq.o_wb_data    = wb_data_q;

endmodule

// File: tb/tb_procyon_victim_wb_queue.sv
// Directed self-checking bench for the victim write-back queue.
// Inputs change on negedge; outputs are checked on negedge.
module tb_procyon_victim_wb_queue;

  localparam int AW = 32;
  localparam int DW = 256;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  procyon_victim_wb_queue_if #(
    .OPTN_ADDR_WIDTH(AW),
    .DC_LINE_WIDTH(DW)
  ) vif ();

  procyon_victim_wb_queue #(
    .OPTN_ADDR_WIDTH(AW),
    .OPTN_DC_LINE_SIZE(32),
    .OPTN_VQ_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vq(vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    vif.i_victim_en   = 1'b0;
    vif.i_victim_addr = '0;
    vif.i_victim_data = '0;
    vif.i_lookup_addr = '0;
    vif.i_wb_ack      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic enq(input logic [AW-1:0] a, input logic [DW-1:0] d);
    vif.i_victim_en   = 1'b1;
    vif.i_victim_addr = a;
    vif.i_victim_data = d;
    tick();
    vif.i_victim_en   = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!vif.o_wb_req && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (vif.o_wb_req !== 1'b1) begin
      $display("FAIL %s_req_timeout got=%b exp=1", nm, vif.o_wb_req);
      n_fail++;
    end
  endtask

  task automatic ack_pulse();
    vif.i_wb_ack = 1'b1;
    tick();
    vif.i_wb_ack = 1'b0;
  endtask

  task automatic drain_one(input string nm, input logic [AW-1:0] ea);
    wait_req(nm);
    n_tests++;
    if (vif.o_wb_addr !== ea) begin
      $display("FAIL %s_addr got=%h exp=%h", nm, vif.o_wb_addr, ea);
      n_fail++;
    end
    n_tests++;
    if (vif.o_wb_data !== pat(ea)) begin
      $display("FAIL %s_data got=%h exp=%h", nm, vif.o_wb_data, pat(ea));
      n_fail++;
    end
    ack_pulse();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({vif.o_wb_req, vif.o_overflow, vif.o_full, vif.o_empty} !== 4'b0001) begin
      $display("FAIL reset_flags got=%b exp=0001",
        {vif.o_wb_req, vif.o_overflow, vif.o_full, vif.o_empty});
      n_fail++;
    end
    n_tests++;
    if (vif.o_wb_addr !== '0 || vif.o_wb_data !== '0) begin
      $display("FAIL reset_bus got=%h/%h exp=0/0", vif.o_wb_addr, vif.o_wb_data);
      n_fail++;
    end
  endtask

  task automatic test_single();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = 32'h0000_1000;
    d = pat(a);
    enq(a, d);
    n_tests++;
    if (vif.o_wb_req !== 1'b0 || vif.o_empty !== 1'b0) begin
      $display("FAIL single_n0 got=req%b empty%b exp=req0 empty0", vif.o_wb_req, vif.o_empty);
      n_fail++;
    end
    tick();
    n_tests++;
    if (vif.o_wb_req !== 1'b0) begin
      $display("FAIL single_n1 got=%b exp=0", vif.o_wb_req);
      n_fail++;
    end
    tick();
    n_tests++;
    if (vif.o_wb_req !== 1'b1 || vif.o_wb_addr !== a || vif.o_wb_data !== d) begin
      $display("FAIL single_n2 got=%b %h exp=1 %h", vif.o_wb_req, vif.o_wb_addr, a);
      n_fail++;
    end
    vif.i_wb_ack = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (vif.o_wb_req !== 1'b1 || vif.o_wb_addr !== a || vif.o_wb_data !== d) begin
      $display("FAIL single_hold got=%b %h exp=1 %h", vif.o_wb_req, vif.o_wb_addr, a);
      n_fail++;
    end
    ack_pulse();
    n_tests++;
    if (vif.o_wb_req !== 1'b0 || vif.o_empty !== 1'b1) begin
      $display("FAIL single_post got=req%b empty%b exp=req0 empty1", vif.o_wb_req, vif.o_empty);
      n_fail++;
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] a;
    vif.i_victim_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      a = AW'(k) << 12;
      vif.i_victim_addr = a;
      vif.i_victim_data = pat(a);
      tick();
      if (k == 3) begin
        n_tests++;
        if (vif.o_full !== 1'b0) begin
          $display("FAIL ovf_full3 got=%b exp=0", vif.o_full);
          n_fail++;
        end
      end
      if (k == 4) begin
        n_tests++;
        if (vif.o_full !== 1'b1 || vif.o_overflow !== 1'b0) begin
          $display("FAIL ovf_full4 got=full%b ovf%b exp=full1 ovf0", vif.o_full, vif.o_overflow);
          n_fail++;
        end
      end
    end
    vif.i_victim_en = 1'b0;
    n_tests++;
    if (vif.o_overflow !== 1'b1 || vif.o_full !== 1'b1) begin
      $display("FAIL ovf_set got=ovf%b full%b exp=ovf1 full1", vif.o_overflow, vif.o_full);
      n_fail++;
    end
    for (int k = 1; k <= 4; k++) drain_one("ovf_drain", AW'(k) << 12);
    n_tests++;
    if (vif.o_empty !== 1'b1) begin
      $display("FAIL ovf_empty got=%b exp=1", vif.o_empty);
      n_fail++;
    end
    repeat (5) begin
      tick();
      n_tests++;
      if (vif.o_wb_req !== 1'b0) begin
        $display("FAIL ovf_extra got=%b %h exp=0", vif.o_wb_req, vif.o_wb_addr);
        n_fail++;
      end
    end
    n_tests++;
    if (vif.o_overflow !== 1'b1) begin
      $display("FAIL ovf_sticky got=%b exp=1", vif.o_overflow);
      n_fail++;
    end
  endtask

  task automatic test_lookup();
    enq(32'h0000_1008, pat(32'h0000_1000));
    vif.i_lookup_addr = 32'h0000_101C;
    #1;
    n_tests++;
    if (vif.o_lookup_hit !== 1'b1) begin
      $display("FAIL lk_101c got=%b exp=1", vif.o_lookup_hit);
      n_fail++;
    end
    vif.i_lookup_addr = 32'h0000_1020;
    #1;
    n_tests++;
    if (vif.o_lookup_hit !== 1'b0) begin
      $display("FAIL lk_1020 got=%b exp=0", vif.o_lookup_hit);
      n_fail++;
    end
    vif.i_lookup_addr = 32'h0000_0FFC;
    #1;
    n_tests++;
    if (vif.o_lookup_hit !== 1'b0) begin
      $display("FAIL lk_0ffc got=%b exp=0", vif.o_lookup_hit);
      n_fail++;
    end
    vif.i_lookup_addr = 32'h0000_1000;
    wait_req("lk");
    n_tests++;
    if (vif.o_lookup_hit !== 1'b1 || vif.o_wb_addr !== 32'h0000_1000) begin
      $display("FAIL lk_busy got=%b %h exp=1 00001000", vif.o_lookup_hit, vif.o_wb_addr);
      n_fail++;
    end
    ack_pulse();
    n_tests++;
    if (vif.o_lookup_hit !== 1'b0) begin
      $display("FAIL lk_after_ack got=%b exp=0", vif.o_lookup_hit);
      n_fail++;
    end
  endtask

  task automatic test_enq_ack_same();
    enq(32'h0000_7000, pat(32'h0000_7000));
    enq(32'h0000_8000, pat(32'h0000_8000));
    wait_req("same");
    n_tests++;
    if (vif.o_wb_addr !== 32'h0000_7000) begin
      $display("FAIL same_first got=%h exp=00007000", vif.o_wb_addr);
      n_fail++;
    end
    vif.i_wb_ack      = 1'b1;
    vif.i_victim_en   = 1'b1;
    vif.i_victim_addr = 32'h0000_6000;
    vif.i_victim_data = pat(32'h0000_6000);
    vif.i_lookup_addr = 32'h0000_6000;
    #1;
    n_tests++;
    if (vif.o_lookup_hit !== 1'b0) begin
      $display("FAIL same_lk_early got=%b exp=0", vif.o_lookup_hit);
      n_fail++;
    end
    tick();
    vif.i_wb_ack    = 1'b0;
    vif.i_victim_en = 1'b0;
    n_tests++;
    if (vif.o_lookup_hit !== 1'b1 || vif.o_full !== 1'b0 || vif.o_empty !== 1'b0) begin
      $display("FAIL same_state got=hit%b full%b empty%b exp=1 0 0",
        vif.o_lookup_hit, vif.o_full, vif.o_empty);
      n_fail++;
    end
    drain_one("same_2nd", 32'h0000_8000);
    drain_one("same_3rd", 32'h0000_6000);
    n_tests++;
    if (vif.o_empty !== 1'b1) begin
      $display("FAIL same_empty got=%b exp=1", vif.o_empty);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      a = AW'(2 * r + 1) << 8;
      enq(a, pat(a));
      a = AW'(2 * r + 2) << 8;
      enq(a, pat(a));
      drain_one("wrap", AW'(2 * r + 1) << 8);
      drain_one("wrap", AW'(2 * r + 2) << 8);
    end
    repeat (4) tick();
    n_tests++;
    if (vif.o_wb_req !== 1'b0 || vif.o_empty !== 1'b1 || vif.o_overflow !== 1'b0) begin
      $display("FAIL wrap_end got=req%b empty%b ovf%b exp=0 1 0",
        vif.o_wb_req, vif.o_empty, vif.o_overflow);
      n_fail++;
    end
  endtask

  task automatic test_async_reset();
    enq(32'h0000_A000, pat(32'h0000_A000));
    enq(32'h0000_B000, pat(32'h0000_B000));
    enq(32'h0000_C000, pat(32'h0000_C000));
    wait_req("arst");
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (vif.o_wb_req !== 1'b0 || vif.o_empty !== 1'b1) begin
      $display("FAIL arst_drop got=req%b empty%b exp=0 1", vif.o_wb_req, vif.o_empty);
      n_fail++;
    end
    tick();
    rst = 1'b0;
    tick();
    for (int k = 10; k <= 12; k++) begin
      vif.i_lookup_addr = AW'(k) << 12;
      #1;
      n_tests++;
      if (vif.o_lookup_hit !== 1'b0) begin
        $display("FAIL arst_lk got=%b exp=0 addr=%h", vif.o_lookup_hit, vif.i_lookup_addr);
        n_fail++;
      end
    end
    repeat (3) tick();
    n_tests++;
    if (vif.o_wb_req !== 1'b0 || vif.o_empty !== 1'b1 || vif.o_wb_addr !== '0) begin
      $display("FAIL arst_after got=req%b empty%b addr%h exp=0 1 0",
        vif.o_wb_req, vif.o_empty, vif.o_wb_addr);
      n_fail++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_overflow();
    test_lookup();
    test_enq_ack_same();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
